// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity encodings, serializer
// states and a parameter legality check.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic bit uart_params_ok(input int clks_per_bit, input int data_bits,
                                          input int parity, input int stop_bits,
                                          input int fifo_depth);
        bit ok;
        ok = (clks_per_bit >= 2);
        ok = ok && (data_bits >= 5) && (data_bits <= 9);
        ok = ok && (parity >= 0) && (parity <= 2);
        ok = ok && ((stop_bits == 1) || (stop_bits == 2));
        ok = ok && (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
        return ok;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with one extra pointer bit so full and empty stay distinct
// when the pointers wrap. Pushes while full and pops while empty are dropped.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: only pointer-covered entries are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered words are serialised LSB first
// with optional parity and one or two stop bits, frames sent back to back.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output tx_state_e                     dbg_state
);
    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [1:0]      PAR_MODE  = 2'(PARITY);
    localparam logic            PAR_SEED  = (PAR_MODE == PAR_ODD);
    localparam bit              PARAMS_OK = uart_params_ok(CLKS_PER_BIT, DATA_BITS, PARITY,
                                                           STOP_BITS, FIFO_DEPTH);

    tx_state_e              state_q, state_d;
    logic [CW-1:0]          baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_rdata;
    logic                   baud_last;

    assert property (@(posedge clk) PARAMS_OK);

    // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
    // tx_valid while tx_ready is low is silently dropped.
    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && tx_ready;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (fifo_push),
        .wdata_i (tx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_last = (baud_q == BAUD_LAST);

    // A word leaves the FIFO when idle, or at the very end of the last stop bit.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_STOP) && baud_last && (bit_q == STOP_LAST)));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_last ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    state_d = ST_START;
                    shift_d = fifo_rdata;
                    par_d   = PAR_SEED;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    par_d   = par_q ^ shift_q[0];
                    if (bit_q == DATA_LAST) begin
                        state_d = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            state_d = ST_START;
                            shift_d = fifo_rdata;
                            par_d   = PAR_SEED;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Line level follows the current state, so tx lags the FSM by one clock.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx        = tx_q;
    assign tx_busy   = (state_q != ST_IDLE) || !fifo_empty;
    assign dbg_state = state_q;

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter: successor to `uart_tx`, adding configurable data width, parity, stop bits and baud divisor, a valid/ready input handshake and an internal transmit FIFO. Host logic pushes words at clock rate; the block serialises them LSB-first onto `tx`, back-to-back while data remains. Sits between the bus/command logic and the board TX pin.

## Interface
- `CLKS_PER_BIT`, 868: clocks per bit period (100 MHz / 115200); legal ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥ 2.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  host offers `tx_data` this cycle.
- `tx_data`  in  DATA_BITS  word to transmit.
- `tx_ready`  out  1  FIFO can accept; high iff FIFO not full.
- `tx`  out  1  serial line; idle high.
- `tx_busy`  out  1  high when serializer not IDLE or FIFO non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: word stored on a rising edge with `tx_valid && tx_ready`. `tx_valid` while `tx_ready` low: word ignored, no error flag.
- Serializer FSM states: IDLE → START → DATA → PARITY (skipped when PARITY=0) → STOP → IDLE or START.
- IDLE: `tx`=1. FIFO non-empty at an edge: pop head into shift register, enter START.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA: DATA_BITS bits, LSB first, CLKS_PER_BIT cycles each; bit index counter 0..DATA_BITS-1.
- PARITY: even → XOR of data bits; odd → inverted XOR.
- STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles. At end: FIFO non-empty → pop and go straight to START (no idle cycle); else IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1, reset to 0 on every state entry; bit advances when it reaches CLKS_PER_BIT-1.
- Push and pop same edge: `fifo_count` unchanged; push to a full FIFO is impossible because `tx_ready`=0 (pop does not raise `tx_ready` until the next cycle).
- `tx` is registered; no combinational path from inputs to `tx`.

## Timing
- Reset (asynchronous assert, synchronous release): `tx`=1, `tx_busy`=0, `tx_ready`=1, `fifo_count`=0, FSM IDLE, FIFO flushed, counters 0.
- Reset mid-frame: `tx` returns to 1 immediately; partial frame is aborted and FIFO contents are lost.
- Latency: word accepted at edge N into an empty FIFO with FSM IDLE → popped at edge N+1 → `tx` low after edge N+2.
- `tx_busy` rises after the accepting edge. It falls after the edge ending the last stop bit with FIFO empty.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles exactly.
- Back-to-back frames: zero idle cycles between the last stop bit and the next start bit.
- Pointer wrap: read/write pointers carry one extra bit, so full and empty are distinguished at wrap-around.

## Structure
- Package `uart_pkg`:
  - parity encodings PAR_NONE/PAR_EVEN/PAR_ODD;
  - serializer state enum;
  - parameter-legality check function.
- Sub-module `uart_fifo`: synchronous FIFO parametrised on width and depth, with `full`, `empty` and `count` outputs. Reused later by the RX path.
- Top module holds the FSM, baud counter, bit counter, shift register and parity accumulator.

## Test plan
- Bench config: CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1.
  - Push 0xAA once → `tx` low 4 cycles, then bits 0,1,0,1,0,1,0,1 × 4 cycles each, then high 4 cycles. Frame is 40 cycles. `tx_busy` falls after the frame.
  - Push 0x55, 0x0F, 0xF0, 0x81 back-to-back → four frames with no idle gap, in push order. `tx_ready` low while `fifo_count`=4. Push of a fifth word while full is ignored.
- PARITY=1 (even), data 0x07 → parity bit 1. PARITY=2 (odd), data 0x07 → parity bit 0. Frame is 44 cycles.
- DATA_BITS=5, STOP_BITS=2, data 5'h13 → bits 1,1,0,0,1, then stop high for 8 cycles. Frame is 32 cycles.
- Assert `rst` low mid-DATA with 3 words queued:
  - `tx`=1 immediately, `fifo_count`=0, `tx_busy`=0;
  - after release, no frame is emitted.
- Fill and drain FIFO_DEPTH+3 words with random `tx_valid` gaps → pointer wrap verified; output sequence equals accepted sequence.
